// File: rtl/fir_task_scheduler.sv
// fir_task_scheduler: arbitrates coefficient-set loads and sample transfers
// into a FIR controller. Optional watchdog on the wait states: FIR_SCHED_TIMEOUT_EN.
module fir_task_scheduler (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       new_coeff_set,
    output logic       coeff_clear,
    input  logic       sample_req,
    output logic       sample_ack,
    input  logic       modwait,
    input  logic       err_in,
    output logic       dr,
    output logic       lc,
    output logic [1:0] coeff_num,
    output logic       busy,
    output logic       sched_err,
    output logic       timeout
);

    // Handshake: new_coeff_set and sample_req are levels sampled only in IDLE;
    // coeff_clear / sample_ack are one-cycle completion pulses; after each lc
    // or dr burst the controller raises modwait once and later drops it.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LC_PULSE = 3'd1,
        LC_BUSY  = 3'd2,
        LC_DONE  = 3'd3,
        DR1      = 3'd4,
        DR2      = 3'd5,
        S_BUSY   = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t     state;
    state_t     base_next;
    state_t     state_next;
    logic [1:0] idx;
    logic       last_grant_coeff;
    logic       wd_fire;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fair arbitration: on a tie the requester that was not served last wins.
    always_comb begin
        base_next = state;
        case (state)
            IDLE: begin
                if (new_coeff_set && (!sample_req || !last_grant_coeff)) begin
                    base_next = LC_PULSE;
                end else if (sample_req) begin
                    base_next = DR1;
                end
            end
            LC_PULSE: base_next = LC_BUSY;
            LC_BUSY:  if (modwait) base_next = LC_DONE;
            LC_DONE: begin
                if (!modwait) begin
                    base_next = (idx == 2'd3) ? IDLE : LC_PULSE;
                end
            end
            DR1:      base_next = DR2;
            DR2:      base_next = S_BUSY;
            S_BUSY:   if (modwait) base_next = S_DONE;
            S_DONE:   if (!modwait) base_next = IDLE;
            default:  base_next = IDLE;
        endcase
    end

    assign state_next = wd_fire ? IDLE : base_next;

`ifdef FIR_SCHED_TIMEOUT_EN
    logic [7:0] wd_cnt;
    logic       timeout_q;
    logic       in_wait;
    logic       next_is_wait;

    assign in_wait      = (state == LC_BUSY) || (state == LC_DONE) ||
                          (state == S_BUSY)  || (state == S_DONE);
    assign next_is_wait = (state_next == LC_BUSY) || (state_next == LC_DONE) ||
                          (state_next == S_BUSY)  || (state_next == S_DONE);

    // The count reaches 255 on the edge that fires, so fire while it reads 254.
    assign wd_fire = in_wait && (base_next == state) && (wd_cnt == 8'd254);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wd_cnt    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wd_fire;
            if (next_is_wait && (state_next != state)) begin
                wd_cnt <= 8'd0;
            end else if (in_wait) begin
                wd_cnt <= wd_cnt + 8'd1;
            end else begin
                wd_cnt <= 8'd0;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    // Bookkeeping registers updated on the transitions that complete work.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            idx              <= 2'd0;
            last_grant_coeff <= 1'b0;
            coeff_clear      <= 1'b0;
            sched_err        <= 1'b0;
        end else begin
            coeff_clear <= 1'b0;
            if (wd_fire) begin
                sched_err <= 1'b1;
                idx       <= 2'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (base_next == DR1) begin
                            sched_err <= 1'b0;
                        end
                    end
                    LC_DONE: begin
                        if (!modwait) begin
                            if (idx == 2'd3) begin
                                coeff_clear      <= 1'b1;
                                idx              <= 2'd0;
                                last_grant_coeff <= 1'b1;
                            end else begin
                                idx <= idx + 2'd1;
                            end
                        end
                    end
                    S_DONE: begin
                        if (!modwait) begin
                            sched_err        <= err_in;
                            last_grant_coeff <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Strobes decode from state (and idx) only, so no input reaches lc or dr.
    always_comb begin
        lc         = 1'b0;
        dr         = 1'b0;
        sample_ack = 1'b0;
        coeff_num  = 2'd0;
        busy       = (state != IDLE);
        case (state)
            LC_PULSE: begin
                lc        = 1'b1;
                coeff_num = idx;
            end
            LC_BUSY, LC_DONE: coeff_num = idx;
            DR1:      dr = 1'b1;
            DR2: begin
                dr         = 1'b1;
                sample_ack = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fir_task_scheduler.sv
// Bench for fir_task_scheduler: round-level reference model with an emulated
// FIR controller; define FIR_SCHED_TIMEOUT_EN to exercise the watchdog.
module tb_fir_task_scheduler;

    logic       clk;
    logic       n_rst;
    logic       new_coeff_set;
    logic       coeff_clear;
    logic       sample_req;
    logic       sample_ack;
    logic       modwait;
    logic       err_in;
    logic       dr;
    logic       lc;
    logic [1:0] coeff_num;
    logic       busy;
    logic       sched_err;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // emulated FIR controller settings
    int resp_delay = 2;
    int resp_len   = 2;
    bit stuck_hi   = 1'b0;
    int resp_phase = 0;
    int resp_cnt   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    logic [1:0] dr_len = 2'd0;
    logic       dr_ack_ok = 1'b0;
    logic       dr_serr = 1'b0;
    bit         busy_chk_en = 1'b1;
    int bad_overlap = 0;
    int bad_ack = 0;
    int bad_cnum = 0;
    int bad_busy = 0;

    // model state: who was served last, and the expected sticky error
    bit m_last_coeff = 1'b0;
    bit m_serr = 1'b0;

    fir_task_scheduler dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .new_coeff_set(new_coeff_set),
        .coeff_clear  (coeff_clear),
        .sample_req   (sample_req),
        .sample_ack   (sample_ack),
        .modwait      (modwait),
        .err_in       (err_in),
        .dr           (dr),
        .lc           (lc),
        .coeff_num    (coeff_num),
        .busy         (busy),
        .sched_err    (sched_err),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller: modwait rises resp_delay+1 cycles after lc / sample_ack, stays resp_len cycles.
    always @(negedge clk) begin
        if (n_rst !== 1'b1) begin
            resp_phase = 0;
            modwait = 1'b0;
        end else if (stuck_hi) begin
            resp_phase = 0;
            modwait = 1'b1;
        end else begin
            case (resp_phase)
                0: begin
                    modwait = 1'b0;
                    if (lc === 1'b1 || sample_ack === 1'b1) begin
                        resp_phase = 1;
                        resp_cnt = resp_delay;
                    end
                end
                1: begin
                    if (resp_cnt == 0) begin
                        modwait = 1'b1;
                        resp_cnt = resp_len - 1;
                        resp_phase = 2;
                    end else begin
                        resp_cnt--;
                    end
                end
                default: begin
                    if (resp_cnt == 0) begin
                        modwait = 1'b0;
                        resp_phase = 0;
                    end else begin
                        resp_cnt--;
                    end
                end
            endcase
        end
    end

    // Event monitor: lc -> 1x (x = coeff_num), coeff_clear -> 20,
    // dr burst -> 3{ack_in_2nd_cycle, sched_err_in_1st_cycle, length}.
    always @(negedge clk) begin
        if (n_rst !== 1'b1) begin
            dr_len = 2'd0;
            dr_ack_ok = 1'b0;
        end else begin
            if (lc && dr) bad_overlap++;
            if ((dr || !busy) && coeff_num != 2'd0) bad_cnum++;
            if (busy_chk_en && modwait && !busy) bad_busy++;
            if (lc) obs_q.push_back({6'h04, coeff_num});
            if (coeff_clear) obs_q.push_back(8'h20);
            if (dr) begin
                if (dr_len == 2'd0) dr_serr = sched_err;
                if (dr_len != 2'd3) dr_len = dr_len + 2'd1;
                if (sample_ack && dr_len == 2'd2) dr_ack_ok = 1'b1;
            end else if (dr_len != 2'd0) begin
                obs_q.push_back({4'h3, dr_ack_ok, dr_serr, dr_len});
                dr_len = 2'd0;
                dr_ack_ok = 1'b0;
            end
            if (sample_ack && !(dr && dr_len == 2'd2)) bad_ack++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_events(input string tag);
        logic [7:0] e;
        logic [7:0] o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hFF;
            chk(tag, 32'(o), 32'(e));
        end
        chk({tag, "_extra_events"}, 32'(obs_q.size()), 32'd0);
        obs_q.delete();
    endtask

    function automatic void push_coeff_set();
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h10 + 8'(k));
        exp_q.push_back(8'h20);
    endfunction

    function automatic void push_sample();
        exp_q.push_back(8'h3A);
    endfunction

    // One round: raise the chosen requests, drop each on its completion pulse.
    task automatic run_round(input string tag, input bit c, input bit s, input bit e);
        bit coeff_first;
        bit done;
        coeff_first = c && (!s || !m_last_coeff);
        if (coeff_first) begin
            push_coeff_set();
            if (s) push_sample();
        end else begin
            push_sample();
            if (c) push_coeff_set();
        end
        m_last_coeff = c && !(coeff_first && s);
        if (s) m_serr = e;

        @(negedge clk);
        err_in = e;
        new_coeff_set = c;
        sample_req = s;
        done = 1'b0;
        for (int guard = 0; guard < 3000 && !done; guard++) begin
            @(negedge clk);
            if (coeff_clear) new_coeff_set = 1'b0;
            if (sample_ack) sample_req = 1'b0;
            if (!new_coeff_set && !sample_req && !busy) done = 1'b1;
        end
        chk({tag, "_completed"}, 32'(done), 32'd1);
        new_coeff_set = 1'b0;
        sample_req = 1'b0;
        @(negedge clk);
        check_events(tag);
        chk({tag, "_sched_err"}, 32'(sched_err), 32'(m_serr));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        obs_q.delete();
        m_last_coeff = 1'b0;
        m_serr = 1'b0;
    endtask

    initial begin
        bit found;
        bit saw;
        int cnt;
        logic [1:0] cs;

        n_rst = 1'b1;
        new_coeff_set = 1'b0;
        sample_req = 1'b0;
        err_in = 1'b0;
        #2 n_rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({dr, lc, coeff_clear, sample_ack, busy, sched_err, timeout, coeff_num}), 32'd0);
        n_rst = 1'b1;
        @(negedge clk);
        chk("reset_idle_busy", 32'(busy), 32'd0);

        resp_delay = 2;
        resp_len = 3;
        run_round("coeff_load", 1'b1, 1'b0, 1'b0);

        resp_delay = 1;
        resp_len = 10;
        run_round("sample", 1'b0, 1'b1, 1'b0);

        do_reset();
        resp_delay = 2;
        resp_len = 2;
        run_round("simul_first", 1'b1, 1'b1, 1'b0);
        run_round("simul_second", 1'b1, 1'b1, 1'b0);

        run_round("err_set", 1'b0, 1'b1, 1'b1);
        run_round("err_clear", 1'b0, 1'b1, 1'b0);

        // Reset while the third coefficient is in flight.
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h12);
        @(negedge clk);
        new_coeff_set = 1'b1;
        found = 1'b0;
        for (int guard = 0; guard < 200 && !found; guard++) begin
            @(negedge clk);
            if (coeff_num == 2'd2) found = 1'b1;
        end
        chk("midrst_reach_idx2", 32'(found), 32'd1);
        @(negedge clk);
        n_rst = 1'b0;
        new_coeff_set = 1'b0;
        #1;
        chk("midrst_outputs", 32'({dr, lc, coeff_clear, sample_ack, busy, sched_err, timeout, coeff_num}), 32'd0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        check_events("midrst_events");
        m_last_coeff = 1'b0;
        m_serr = 1'b0;
        run_round("post_rst_coeff", 1'b1, 1'b0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            cs = 2'($urandom_range(1, 3));
            resp_delay = $urandom_range(0, 4);
            resp_len = $urandom_range(1, 6);
            run_round($sformatf("rand%0d", r), cs[1], cs[0], 1'($urandom_range(0, 1)));
        end

        chk("lc_dr_overlap", 32'(bad_overlap), 32'd0);
        chk("stray_sample_ack", 32'(bad_ack), 32'd0);
        chk("coeff_num_outside_lc", 32'(bad_cnum), 32'd0);
        chk("busy_while_modwait", 32'(bad_busy), 32'd0);

        // Controller hangs with modwait stuck high during a sample.
        busy_chk_en = 1'b0;
        err_in = 1'b1;
        stuck_hi = 1'b1;
        exp_q.push_back(8'h3A);
        repeat (2) @(negedge clk);
        sample_req = 1'b1;
        found = 1'b0;
        for (int guard = 0; guard < 20 && !found; guard++) begin
            @(negedge clk);
            if (sample_ack) found = 1'b1;
        end
        sample_req = 1'b0;
        chk("stuck_sample_ack", 32'(found), 32'd1);
`ifdef FIR_SCHED_TIMEOUT_EN
        found = 1'b0;
        cnt = 0;
        for (int guard = 0; guard < 400 && !found; guard++) begin
            @(negedge clk);
            cnt++;
            if (timeout) found = 1'b1;
        end
        chk("wd_latency", 32'(cnt), 32'd257);
        chk("wd_sched_err", 32'(sched_err), 32'd1);
        chk("wd_idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("wd_pulse_width", 32'(timeout), 32'd0);
        stuck_hi = 1'b0;
`else
        saw = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (timeout !== 1'b0) saw = 1'b1;
        end
        chk("no_wd_timeout", 32'(saw), 32'd0);
        chk("no_wd_still_busy", 32'(busy), 32'd1);
        stuck_hi = 1'b0;
        found = 1'b0;
        for (int guard = 0; guard < 20 && !found; guard++) begin
            @(negedge clk);
            if (!busy) found = 1'b1;
        end
        chk("no_wd_release", 32'(found), 32'd1);
        chk("no_wd_sched_err", 32'(sched_err), 32'd1);
`endif
        repeat (3) @(negedge clk);
        check_events("stuck_events");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
